// File: rtl/capture_pkg.sv
// Shared encodings for the triggered ping-pong capture buffer.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAP  = 2'd2
    } state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    function automatic logic edge_hit(input logic prev, input logic cur, input logic edge_sel);
        logic hit;
        case (edge_sel)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = prev & ~cur;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module sdp_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage write and registered read; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_capture_buf.sv
// Triggered ping-pong sample buffer: one bank fills with decimated ADC samples
// after a trigger edge while the other is shown; banks swap only on frame completion.
module pingpong_capture_buf
    import capture_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 200,
    parameter int AW    = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             trig_edge,
    input  logic             single_mode,
    input  logic             arm,
    input  logic [DIV_W-1:0] decim,
    input  logic [DW-1:0]    ad_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic             frame_ready,
    output logic             frame_valid,
    output logic             busy,
    output logic             disp_bank
);

    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]      DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]    PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DW-1:0]    DATA_ZERO = DW'(0);

    logic             trig_s1_q, trig_s2_q, trig_s3_q;
    logic             trig_hit_s;
    state_e           state_q;
    logic [DIV_W-1:0] dec_lat_q, div_cnt_q, div_cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             strobe_s, last_s;
    logic             disp_bank_q, frame_ready_q, frame_valid_q, busy_q;
    logic             rd_sel_q, rd_oor_q;
    logic [DW-1:0]    rd_data_q, bank0_rdata_s, bank1_rdata_s;
    logic             bank0_we_s, bank1_we_s;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
        end else begin
            trig_s1_q <= trig_in;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
        end
    end

    assign trig_hit_s = edge_hit(trig_s3_q, trig_s2_q, trig_edge);

    // Timebase divider and write pointer progression during capture.
    always_comb begin
        strobe_s  = 1'b0;
        last_s    = 1'b0;
        div_cnt_d = div_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        if (state_q == ST_CAP) begin
            strobe_s = (div_cnt_q == DIV_ZERO);
            last_s   = strobe_s && (wr_ptr_q == LAST_ADDR);
            if (div_cnt_q == dec_lat_q) begin
                div_cnt_d = DIV_ZERO;
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
            if (strobe_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end else begin
            strobe_s  = 1'b0;
            last_s    = 1'b0;
            div_cnt_d = div_cnt_q;
            wr_ptr_d  = wr_ptr_q;
        end
    end

    // Capture FSM with registered status outputs; the bank swap lands on the edge of the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dec_lat_q     <= DIV_ZERO;
            div_cnt_q     <= DIV_ZERO;
            wr_ptr_q      <= PTR_ZERO;
            disp_bank_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_ready_q <= 1'b0;
            div_cnt_q     <= div_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            case (state_q)
                ST_IDLE: begin
                    if (!single_mode || arm) begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (trig_hit_s) begin
                        state_q   <= ST_CAP;
                        dec_lat_q <= decim;
                        div_cnt_q <= DIV_ZERO;
                        wr_ptr_q  <= PTR_ZERO;
                    end
                end
                ST_CAP: begin
                    if (last_s) begin
                        disp_bank_q   <= ~disp_bank_q;
                        frame_ready_q <= 1'b1;
                        frame_valid_q <= 1'b1;
                        if (single_mode) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Only the write bank (the one not on display) ever sees a write enable.
    assign bank0_we_s = strobe_s & disp_bank_q;
    assign bank1_we_s = strobe_s & ~disp_bank_q;

    sdp_ram #(.DW(DW), .AW(AW)) bank0 (
        .clk_i   (clk),
        .we_i    (bank0_we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (ad_data),
        .raddr_i (rd_addr),
        .rdata_o (bank0_rdata_s)
    );

    sdp_ram #(.DW(DW), .AW(AW)) bank1 (
        .clk_i   (clk),
        .we_i    (bank1_we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (ad_data),
        .raddr_i (rd_addr),
        .rdata_o (bank1_rdata_s)
    );

    // Read-side bank select and range guard, captured alongside the RAM address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_q <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            rd_sel_q <= disp_bank_q;
            rd_oor_q <= ({1'b0, rd_addr} >= DEPTH_EXT);
        end
    end

    // Display output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= DATA_ZERO;
        end else if (rd_oor_q) begin
            rd_data_q <= DATA_ZERO;
        end else if (rd_sel_q) begin
            rd_data_q <= bank1_rdata_s;
        end else begin
            rd_data_q <= bank0_rdata_s;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_ready = frame_ready_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign disp_bank   = disp_bank_q;

endmodule

// File: tb/tb_pingpong_capture_buf.sv
// Self-checking bench: cycle-level behavioural model of the capture buffer plus directed literal checks.
module tb_pingpong_capture_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 200;
    localparam int AW    = 8;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n, trig_in, trig_edge, single_mode, arm;
    logic [DIV_W-1:0] decim;
    logic [DW-1:0]    ad_data;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             frame_ready, frame_valid, busy, disp_bank;

    always #5 clk = ~clk;

    pingpong_capture_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_in     (trig_in),
        .trig_edge   (trig_edge),
        .single_mode (single_mode),
        .arm         (arm),
        .decim       (decim),
        .ad_data     (ad_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .busy        (busy),
        .disp_bank   (disp_bank)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fr_count = 0;
    bit ramp_en = 1'b0;
    bit rnd_en = 1'b0;

    // Model: mode 0 = idle, 1 = waiting for trigger, 2 = capturing.
    int            m_mode, m_k, m_start, m_dec;
    logic [2:0]    m_hist;
    logic          m_disp, m_fr, m_fv, m_busy;
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_known [2][DEPTH];
    logic [DW-1:0] m_rd, m_stage;
    bit            m_rd_known, m_stage_known;
    logic [DW-1:0] sw [DEPTH+1];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_hist = 3'b000;
        m_disp = 1'b0;
        m_fr = 1'b0;
        m_fv = 1'b0;
        m_busy = 1'b0;
        m_rd = '0;
        m_rd_known = 1'b1;
        m_stage = '0;
        m_stage_known = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) m_known[b][i] = 1'b0;
    endtask

    // One rising clock edge of the specified behaviour, using the inputs held across that edge.
    task automatic model_edge();
        bit hit;
        int off, idx, wb;
        m_k++;
        hit = trig_edge ? (m_hist[2] & ~m_hist[1]) : (m_hist[1] & ~m_hist[2]);
        m_hist = {m_hist[1:0], trig_in};
        m_rd = m_stage;
        m_rd_known = m_stage_known;
        if (int'(rd_addr) >= DEPTH) begin
            m_stage = '0;
            m_stage_known = 1'b1;
        end else begin
            m_stage = m_mem[m_disp][rd_addr];
            m_stage_known = m_known[m_disp][rd_addr];
        end
        m_fr = 1'b0;
        case (m_mode)
            0: if (!single_mode || arm) m_mode = 1;
            1: if (hit) begin
                m_mode = 2;
                m_start = m_k;
                m_dec = int'(decim);
            end
            2: begin
                off = m_k - m_start - 1;
                if (off % (m_dec + 1) == 0) begin
                    idx = off / (m_dec + 1);
                    wb = m_disp ? 0 : 1;
                    m_mem[wb][idx] = ad_data;
                    m_known[wb][idx] = 1'b1;
                    if (idx == DEPTH - 1) begin
                        m_disp = ~m_disp;
                        m_fr = 1'b1;
                        m_fv = 1'b1;
                        m_mode = single_mode ? 0 : 1;
                    end
                end
            end
            default: m_mode = 0;
        endcase
        m_busy = (m_mode != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        check("frame_ready", frame_ready, m_fr);
        check("frame_valid", frame_valid, m_fv);
        check("busy", busy, m_busy);
        check("disp_bank", disp_bank, m_disp);
        if (m_rd_known) check("rd_data", rd_data, m_rd);
        if (frame_ready) fr_count++;
        if (ramp_en) ad_data = ad_data + 8'd1;
        else if (rnd_en) ad_data = DW'($urandom);
    endtask

    task automatic wait_frame(input int budget, input string name);
        int start_cnt = fr_count;
        int n = 0;
        while (fr_count == start_cnt && n < budget) begin
            tick();
            n++;
        end
        check({name, " frame_ready seen"}, longint'(fr_count != start_cnt), 1);
    endtask

    task automatic trig_pulse(input int len);
        trig_in = 1'b1;
        repeat (len) tick();
        trig_in = 1'b0;
    endtask

    task automatic sweep();
        for (int i = 0; i <= DEPTH + 1; i++) begin
            if (i <= DEPTH) rd_addr = AW'(i);
            tick();
            if (i >= 1) sw[i-1] = rd_data;
        end
    endtask

    task automatic ramp_check(input int stp, input string name);
        int nerr = 0;
        logic [DW-1:0] d;
        for (int k = 0; k < DEPTH - 1; k++) begin
            d = sw[k+1] - sw[k];
            if (int'(d) != stp) nerr++;
        end
        check({name, " spacing errors"}, nerr, 0);
        check({name, " out-of-range read"}, sw[DEPTH], 0);
    endtask

    initial begin
        int f0;
        rst_n = 1'b0; trig_in = 1'b0; trig_edge = 1'b0; single_mode = 1'b0; arm = 1'b0;
        decim = '0; ad_data = '0; rd_addr = '0;
        m_k = 0;
        model_reset();
        #2;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset frame_valid", frame_valid, 0);
        check("reset disp_bank", disp_bank, 0);
        check("reset rd_data", rd_data, 0);
        rst_n = 1'b1;

        // No trigger: waits forever, no frame
        repeat (30) tick();
        check("no-trig busy", busy, 1);
        check("no-trig frame_ready count", fr_count, 0);
        check("no-trig frame_valid", frame_valid, 0);

        // Ramp, decim 0, rising edge
        ramp_en = 1'b1;
        trig_pulse(4);
        wait_frame(DEPTH + 20, "ramp d0");
        check("ramp d0 frame_valid", frame_valid, 1);
        check("ramp d0 disp_bank", disp_bank, 1);
        sweep();
        ramp_check(1, "ramp d0");

        // decim 3 on falling edge; decim changes after the trigger must not matter
        decim = 16'd3;
        trig_edge = 1'b1;
        tick();
        trig_pulse(6);
        repeat (6) tick();
        decim = 16'd7;
        wait_frame(4 * DEPTH + 40, "falling d3");
        check("falling d3 disp_bank", disp_bank, 0);
        sweep();
        ramp_check(4, "falling d3");

        // Extra trigger edges during capture are ignored
        decim = 16'd1;
        trig_edge = 1'b0;
        f0 = fr_count;
        trig_pulse(4);
        for (int j = 0; j < 8; j++) begin
            repeat (10) tick();
            trig_in = ~trig_in;
        end
        wait_frame(2 * DEPTH + 40, "retrigger");
        repeat (20) tick();
        check("retrigger frame count", fr_count - f0, 1);
        sweep();
        ramp_check(2, "retrigger d1");

        // Randomised traffic against the model
        ramp_en = 1'b0;
        rnd_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) trig_in = ~trig_in;
            if ($urandom_range(0, 399) == 0) trig_edge = ~trig_edge;
            if ($urandom_range(0, 599) == 0) single_mode = ~single_mode;
            arm = ($urandom_range(0, 49) == 0);
            decim = DIV_W'($urandom_range(0, 3));
            rd_addr = AW'($urandom_range(0, 255));
            tick();
        end
        rnd_en = 1'b0;
        arm = 1'b0;

        // Single-shot: triggers ignored until armed
        single_mode = 1'b1;
        trig_in = 1'b0;
        trig_edge = 1'b0;
        decim = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        f0 = fr_count;
        repeat (3) begin
            trig_pulse(5);
            repeat (5) tick();
        end
        check("single unarmed busy", busy, 0);
        check("single unarmed frames", fr_count - f0, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("single armed busy", busy, 1);
        ramp_en = 1'b1;
        trig_pulse(4);
        wait_frame(DEPTH + 20, "single");
        repeat (3) tick();
        check("single done busy", busy, 0);
        check("single done frame_valid", frame_valid, 1);
        f0 = fr_count;
        trig_pulse(4);
        repeat (30) tick();
        check("single no rearm frames", fr_count - f0, 0);

        // Reset part-way through a frame
        single_mode = 1'b0;
        repeat (2) tick();
        trig_pulse(4);
        repeat (96) tick();
        rst_n = 1'b0;
        tick();
        check("midreset frame_ready", frame_ready, 0);
        check("midreset frame_valid", frame_valid, 0);
        check("midreset busy", busy, 0);
        check("midreset disp_bank", disp_bank, 0);
        check("midreset rd_data", rd_data, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        trig_pulse(4);
        wait_frame(DEPTH + 20, "post-reset");
        check("post-reset disp_bank", disp_bank, 1);
        sweep();
        ramp_check(1, "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
